// File: rtl/m_unit_dispatch.sv
// EX-stage dispatcher for the RV32M multiply/divide unit: launches M ops,
// stalls the pipeline while they are in flight and returns a one-beat writeback.
//
// state | meaning
// IDLE  | no op in flight; launch when an M op is in EX and the unit is free
// ISSUE | one-cycle launch pulse to the M unit
// WAIT  | op in flight, pipeline stalled, watchdog running
// DONE  | one-cycle writeback beat, pipeline released
// DRAIN | op flushed; swallow its late result, pipeline free to refetch
module m_unit_dispatch #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_valid,
  input  logic [31:0] ex_instruction,
  input  logic [31:0] ex_rs1_data,
  input  logic [31:0] ex_rs2_data,
  input  logic        flush,
  output logic        m_valid,
  output logic [31:0] m_instruction,
  output logic [31:0] m_rs1,
  output logic [31:0] m_rs2,
  input  logic        m_ready,
  input  logic [31:0] m_rd,
  input  logic        m_busy,
  output logic        stall,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd_addr,
  output logic [31:0] wb_data,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } state_t;

  // Watchdog is a down-counter; hitting zero in WAIT/DRAIN aborts the op on
  // the cycle that makes TIMEOUT_CYCLES cycles since launch.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 2);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       rd_q;
  logic             is_m;
  logic             cnt_tc;
  logic             in_flight;

  assign is_m = ex_valid
             && (ex_instruction[6:0] == 7'b0110011)
             && (ex_instruction[31:25] == 7'b0000001);
  assign cnt_tc    = (cnt == '0);
  assign in_flight = (state == S_WAIT) || (state == S_DRAIN);

  always_comb begin
    stall = 1'b0;
    case (state)
      S_IDLE:  stall = is_m & ~flush;
      S_ISSUE: stall = 1'b1;
      S_WAIT:  stall = ~flush;
      S_DRAIN: stall = is_m;
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= S_IDLE;
      cnt           <= '0;
      rd_q          <= '0;
      m_valid       <= 1'b0;
      m_instruction <= '0;
      m_rs1         <= '0;
      m_rs2         <= '0;
      wb_valid      <= 1'b0;
      wb_we         <= 1'b0;
      wb_rd_addr    <= '0;
      wb_data       <= '0;
      timeout_err   <= 1'b0;
    end else begin
      m_valid     <= 1'b0;
      wb_valid    <= 1'b0;
      wb_we       <= 1'b0;
      timeout_err <= 1'b0;

      if (in_flight && !cnt_tc)
        cnt <= cnt - 1'b1;

      case (state)
        S_IDLE: begin
          if (is_m && !flush && !m_busy) begin
            m_instruction <= ex_instruction;
            m_rs1         <= ex_rs1_data;
            m_rs2         <= ex_rs2_data;
            rd_q          <= ex_instruction[11:7];
            cnt           <= CNT_LOAD;
            m_valid       <= 1'b1;
            state         <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          // A flush wins over a same-cycle result: the op no longer exists.
          if (flush) begin
            state <= m_ready ? S_IDLE : S_DRAIN;
          end else if (m_ready) begin
            wb_data    <= m_rd;
            wb_valid   <= 1'b1;
            wb_we      <= (rd_q != 5'd0);
            wb_rd_addr <= rd_q;
            state      <= S_DONE;
          end else if (cnt_tc) begin
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end
        end
        S_DONE: state <= S_IDLE;
        S_DRAIN: begin
          if (m_ready) begin
            state <= S_IDLE;
          end else if (cnt_tc) begin
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
